// File: rtl/vocoder_mixer.sv
// Vocoder mixer: snapshots one frame of per-band carrier and envelope samples,
// accumulates their Q-format products through a single shared multiplier (one
// band per clock), then outputs the saturated sum as one signed sample.
module vocoder_mixer #(
    parameter int NUM_BANDS = 9,
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              valid_in,
    input  logic [NUM_BANDS-1:0][WIDTH-1:0]   carrier_in,
    input  logic [NUM_BANDS-1:0][WIDTH-1:0]   envelope_in,
    input  logic [NUM_BANDS-1:0]              band_en_in,
    output logic signed [WIDTH-1:0]           sample_out,
    output logic                              valid_out,
    output logic                              busy_out,
    output logic                              overrun_out
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int TERM_W = PROD_W - FRAC_BITS;
    // Headroom of clog2(NUM_BANDS) bits means the running sum can never wrap.
    localparam int ACC_W  = TERM_W + $clog2(NUM_BANDS);
    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_accept;
    logic                      w_last;

    // Frame snapshot; only ever read after it has been loaded, so never reset.
    logic [WIDTH-1:0]          r_carrier  [NUM_BANDS];
    logic [WIDTH-1:0]          r_envelope [NUM_BANDS];
    logic [NUM_BANDS-1:0]      r_band_en;

    logic [IDX_W-1:0]          r_k;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [WIDTH-1:0]   r_sample;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_overrun;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_shift;
    logic signed [TERM_W-1:0]  w_term_trunc;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_acc_sum;
    logic [ACC_W-WIDTH:0]      w_hi;
    logic                      w_fits;
    logic signed [WIDTH-1:0]   w_sat;

    assign w_last = (r_k == IDX_W'(NUM_BANDS - 1));

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a new frame is only taken while fully idle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_accept     = 1'b1;
                    w_state_next = MAC;
                end
            end
            MAC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the whole frame on acceptance so later input changes are irrelevant.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_carrier[i]  <= carrier_in[i];
                r_envelope[i] <= envelope_in[i];
            end
            r_band_en <= band_en_in;
        end
    end

    // Shared multiplier: full-precision product, floor shift back to Q format,
    // then sign-extend to accumulator width. Disabled bands add zero.
    always_comb begin
        w_prod       = $signed(r_carrier[r_k]) * $signed(r_envelope[r_k]);
        w_shift      = w_prod >>> FRAC_BITS;
        w_term_trunc = w_shift[TERM_W-1:0];
        w_term       = r_band_en[r_k] ? ACC_W'(w_term_trunc) : '0;
        w_acc_sum    = r_acc + w_term;
    end

    // Clamp the final sum to the output range: it fits only if every bit above
    // the output sign bit matches that sign bit.
    always_comb begin
        w_hi   = w_acc_sum[ACC_W-1:WIDTH-1];
        w_fits = (&w_hi) | ~(|w_hi);
        if (w_fits) begin
            w_sat = w_acc_sum[WIDTH-1:0];
        end else if (w_acc_sum[ACC_W-1]) begin
            w_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Datapath and status flags. The result is registered on the last MAC
    // edge so it is presented during the DONE cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_k       <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_busy    <= (w_state_next != IDLE);
            r_overrun <= valid_in && (r_state != IDLE);
            if (w_accept) begin
                r_acc <= '0;
                r_k   <= '0;
            end else if (r_state == MAC) begin
                r_acc <= w_acc_sum;
                r_k   <= r_k + IDX_W'(1);
                if (w_last) begin
                    r_sample <= w_sat;
                    r_valid  <= 1'b1;
                end
            end
        end
    end

    assign sample_out  = r_sample;
    assign valid_out   = r_valid;
    assign busy_out    = r_busy;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_vocoder_mixer.sv
// Directed bench for vocoder_mixer: reset, mixing arithmetic, masking,
// saturation, overrun handling, back-to-back acceptance and mid-mix reset.
module tb_vocoder_mixer;

    localparam int NB = 9;
    localparam int W  = 32;

    logic                   clk_in = 1'b0;
    logic                   rst_in = 1'b0;
    logic                   valid_in = 1'b0;
    logic [NB-1:0][W-1:0]   carrier_in;
    logic [NB-1:0][W-1:0]   envelope_in;
    logic [NB-1:0]          band_en_in;
    logic signed [W-1:0]    sample_out;
    logic                   valid_out;
    logic                   busy_out;
    logic                   overrun_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;

    vocoder_mixer #(.NUM_BANDS(NB), .WIDTH(W), .FRAC_BITS(16)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .carrier_in  (carrier_in),
        .envelope_in (envelope_in),
        .band_en_in  (band_en_in),
        .sample_out  (sample_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_all(input logic [W-1:0] c, input logic [W-1:0] e, input logic [NB-1:0] m);
        for (int i = 0; i < NB; i++) begin
            carrier_in[i]  = c;
            envelope_in[i] = e;
        end
        band_en_in = m;
    endtask

    // Pulse valid_in for one cycle; returns in the cycle after the accept edge.
    task automatic pulse_valid();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    // Returns how many cycles after the valid_in cycle valid_out rose
    // (counting the current cycle as 1), or -1 if it never rose in 20 cycles.
    task automatic wait_valid(output int latency);
        bit found;
        found   = 1'b0;
        latency = -1;
        for (int i = 1; i <= 20; i++) begin
            if (!found && valid_out) begin
                latency = i;
                found   = 1'b1;
            end
            if (!found) tick();
        end
    endtask

    task automatic test_reset();
        set_all(32'h0, 32'h0, '0);
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        n_cmp++; if (sample_out !== 32'sd0) begin n_fail++; $display("FAIL reset_sample: got %h want %h", sample_out, 32'h0); end
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_cmp++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_out); end
        $display("reset: sample=%h valid=%b busy=%b overrun=%b", sample_out, valid_out, busy_out, overrun_out);
    endtask

    task automatic test_unity();
        set_all(32'h0001_0000, 32'h0001_0000, 9'h1FF);
        pulse_valid();
        n_cmp++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL unity_busy_start: got %b want 1", busy_out); end
        wait_valid(lat);
        n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL unity_latency: got %0d want 10", lat); end
        n_cmp++; if (sample_out !== 32'sh0009_0000) begin n_fail++; $display("FAIL unity_sample: got %h want %h", sample_out, 32'h0009_0000); end
        n_cmp++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL unity_busy_done: got %b want 1", busy_out); end
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL unity_valid_pulse: got %b want 0", valid_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL unity_busy_end: got %b want 0", busy_out); end
        n_cmp++; if (sample_out !== 32'sh0009_0000) begin n_fail++; $display("FAIL unity_hold: got %h want %h", sample_out, 32'h0009_0000); end
        $display("unity: latency=%0d sample=%h", lat, sample_out);
    endtask

    task automatic test_negative();
        set_all(32'h0, 32'h0, 9'h1FF);
        carrier_in[0]  = 32'hFFFF_0000;
        envelope_in[0] = 32'h0002_0000;
        pulse_valid();
        wait_valid(lat);
        n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL neg_latency: got %0d want 10", lat); end
        n_cmp++; if (sample_out !== -32'sd131072) begin n_fail++; $display("FAIL neg_sample: got %h want %h", sample_out, 32'hFFFE_0000); end
        $display("negative: sample=%h", sample_out);
        tick();
    endtask

    task automatic test_mask();
        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF, 9'h008);
        carrier_in[3]  = 32'h0003_0000;
        envelope_in[3] = 32'h0001_0000;
        pulse_valid();
        wait_valid(lat);
        n_cmp++; if (sample_out !== 32'sh0003_0000) begin n_fail++; $display("FAIL mask_sample: got %h want %h", sample_out, 32'h0003_0000); end
        $display("mask: sample=%h", sample_out);
        tick();
    endtask

    task automatic test_saturation();
        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF, 9'h1FF);
        pulse_valid();
        wait_valid(lat);
        n_cmp++; if (sample_out !== 32'sh7FFF_FFFF) begin n_fail++; $display("FAIL sat_max: got %h want %h", sample_out, 32'h7FFF_FFFF); end
        $display("sat_max: sample=%h", sample_out);
        tick();
        set_all(32'h8000_0000, 32'h7FFF_FFFF, 9'h1FF);
        pulse_valid();
        wait_valid(lat);
        n_cmp++; if (sample_out !== 32'sh8000_0000) begin n_fail++; $display("FAIL sat_min: got %h want %h", sample_out, 32'h8000_0000); end
        $display("sat_min: sample=%h", sample_out);
        tick();
    endtask

    task automatic test_overrun();
        set_all(32'h0001_0000, 32'h0001_0000, 9'h1FF);
        pulse_valid();                       // now in cycle 1
        tick(); tick(); tick();              // cycle 4
        set_all(32'h0, 32'h0, '0);
        pulse_valid();                       // ignored, cycle 5
        n_cmp++; if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", overrun_out); end
        tick();                              // cycle 6
        n_cmp++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b want 0", overrun_out); end
        wait_valid(lat);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL ovr_latency: got %0d want 5", lat); end
        n_cmp++; if (sample_out !== 32'sh0009_0000) begin n_fail++; $display("FAIL ovr_sample: got %h want %h", sample_out, 32'h0009_0000); end
        $display("overrun: latency_from_c6=%0d sample=%h", lat, sample_out);
        tick();                              // cycle 11: accept next frame
        set_all(32'h0, 32'h0, 9'h1FF);
        carrier_in[0]  = 32'hFFFF_0000;
        envelope_in[0] = 32'h0002_0000;
        pulse_valid();
        n_cmp++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL next_no_overrun: got %b want 0", overrun_out); end
        n_cmp++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL next_busy: got %b want 1", busy_out); end
        wait_valid(lat);
        n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL next_latency: got %0d want 10", lat); end
        n_cmp++; if (sample_out !== -32'sd131072) begin n_fail++; $display("FAIL next_sample: got %h want %h", sample_out, 32'hFFFE_0000); end
        $display("back_to_back: latency=%0d sample=%h", lat, sample_out);
        tick();
    endtask

    task automatic test_done_overrun();
        set_all(32'h0001_0000, 32'h0001_0000, 9'h1FF);
        pulse_valid();
        wait_valid(lat);                     // valid_out cycle
        set_all(32'h0003_0000, 32'h0001_0000, 9'h1FF);
        pulse_valid();                       // arrives on the DONE->IDLE edge
        n_cmp++; if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL done_overrun: got %b want 1", overrun_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL done_not_accepted: got %b want 0", busy_out); end
        wait_valid(lat);
        n_cmp++; if (lat !== -1) begin n_fail++; $display("FAIL done_no_valid: got %0d want -1", lat); end
        $display("done_overrun: overrun seen, extra latency=%0d", lat);
    endtask

    task automatic test_reset_mid();
        set_all(32'h0001_0000, 32'h0001_0000, 9'h1FF);
        pulse_valid();                       // cycle 1
        tick(); tick(); tick(); tick();      // cycle 5
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        n_cmp++; if (sample_out !== 32'sd0) begin n_fail++; $display("FAIL mid_rst_sample: got %h want %h", sample_out, 32'h0); end
        n_cmp++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", valid_out); end
        wait_valid(lat);
        n_cmp++; if (lat !== -1) begin n_fail++; $display("FAIL mid_rst_aborted: got %0d want -1", lat); end
        pulse_valid();
        wait_valid(lat);
        n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL post_rst_latency: got %0d want 10", lat); end
        n_cmp++; if (sample_out !== 32'sh0009_0000) begin n_fail++; $display("FAIL post_rst_sample: got %h want %h", sample_out, 32'h0009_0000); end
        $display("reset_mid: latency=%0d sample=%h", lat, sample_out);
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_unity();
        test_negative();
        test_mask();
        test_saturation();
        test_overrun();
        test_done_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
